// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button conditioning block.
//   - default counter widths
//   - debounce FSM state encoding
package button_debounce_pkg;

  // 2^14 cycles ~ 16 ms and 2^20 cycles ~ 1 s at the 1 MHz test clock
  localparam int DEBOUNCE_WIDTH_DEF = 14;
  localparam int LONG_WIDTH_DEF     = 20;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/button_debounce_sync_ff2.sv
// sync_ff2: two-flop synchroniser for a single asynchronous bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised output (two clk edges of latency)
// RST_VAL sets the value both flops take in reset, so an idle active-low
// input does not produce a spurious edge right after reset.
module sync_ff2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{RST_VAL}};
    else        sync_q <= {sync_q[0], d};
  end

  assign q = sync_q[1];

endmodule

// File: rtl/button_debounce.sv
// button_debounce: conditions the raw active-low push-button pin.
//   clk, rst_n     : clock, asynchronous active-low reset
//   button_raw_n   : raw pin, active-low, asynchronous to clk
//   button_n_db    : debounced level, active-low (0 = pressed)
//   press_pulse    : 1-cycle pulse when a press is accepted
//   release_pulse  : 1-cycle pulse when a release is accepted
//   long_press     : 1-cycle pulse, at most once per accepted press
// A level is accepted once the synchronised pin has held it for
// 2^DEBOUNCE_WIDTH cycles; any opposite sample restarts qualification.
// long_press fires 2^LONG_WIDTH held cycles after the press is accepted.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF,
  parameter int LONG_WIDTH     = LONG_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw_n,
  output logic button_n_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  logic                      s2;
  db_state_e                 state;
  logic [DEBOUNCE_WIDTH-1:0] deb_cnt;
  logic [LONG_WIDTH-1:0]     long_cnt;
  logic                      long_done;

  // Reset to 1 = released, matching the idle pin level.
  sync_ff2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button_raw_n),
    .q     (s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      long_cnt      <= '0;
      long_done     <= 1'b0;
      button_n_db   <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      case (state)
        RELEASED: begin
          if (!s2) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (s2) begin
            state <= RELEASED;               // bounce: drop silently
          end else if (&deb_cnt) begin
            state       <= PRESSED;
            button_n_db <= 1'b0;
            press_pulse <= 1'b1;
            long_cnt    <= '0;
            long_done   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (s2) begin
            state   <= RELEASE_WAIT;         // long_cnt holds across a glitch
            deb_cnt <= '0;
          end else if (&long_cnt) begin
            if (!long_done) begin
              long_press <= 1'b1;
              long_done  <= 1'b1;
            end
          end else begin
            long_cnt <= long_cnt + 1'b1;     // saturates at all-ones
          end
        end
        RELEASE_WAIT: begin
          if (!s2) begin
            state <= PRESSED;                // glitch: long state kept
          end else if (&deb_cnt) begin
            state         <= RELEASED;
            button_n_db   <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomised and directed bench for button_debounce (DEBOUNCE_WIDTH=4,
// LONG_WIDTH=6) against a run-length reference model of the pin.
module tb_button_debounce;

  localparam int DW         = 4;
  localparam int LW         = 6;
  localparam int DEB_EDGES  = (1 << DW) + 1; // consecutive FSM samples to accept
  localparam int LONG_EDGES = 1 << LW;       // held cycles after accept

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button_raw_n = 1'b1;
  logic button_n_db, press_pulse, release_pulse, long_press;

  button_debounce #(.DEBOUNCE_WIDTH(DW), .LONG_WIDTH(LW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_raw_n  (button_raw_n),
    .button_n_db   (button_n_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw pin delayed two samples, accepted level flips after
  // DEB_EDGES consecutive opposite samples, long press on the LONG_EDGES-th
  // held cycle (held = this sample and the previous one both pressed).
  logic h1, h2, m_prev, m_db, m_press, m_rel, m_long, m_fired;
  int   run, held;

  task automatic model_reset();
    h1 = 1'b1; h2 = 1'b1; m_prev = 1'b1; m_db = 1'b1;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_fired = 1'b0;
    run = 0; held = 0;
  endtask

  task automatic model_step();
    logic s;
    s = h2; h2 = h1; h1 = button_raw_n;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    run = (s != m_db) ? run + 1 : 0;
    if (run == DEB_EDGES) begin
      run  = 0;
      m_db = s;
      if (!s) begin m_press = 1'b1; held = 0; m_fired = 1'b0; end
      else    m_rel = 1'b1;
    end else if (!m_db && !s && !m_prev) begin
      held++;
      if (held == LONG_EDGES && !m_fired) begin m_long = 1'b1; m_fired = 1'b1; end
    end
    m_prev = s;
  endtask

  // Edge bookkeeping; edge_no is -1 until the first edge after a stimulus change.
  int edge_no, press_edge, rel_edge, long_edge;
  int press_cnt, rel_cnt, long_cnt_seen;

  task automatic mark(input logic v);
    button_raw_n = v;
    edge_no = -1; press_edge = -1; rel_edge = -1; long_edge = -1;
  endtask

  task automatic clr_counts();
    press_cnt = 0; rel_cnt = 0; long_cnt_seen = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    edge_no++;
    #1;
    chk("db",      {31'd0, button_n_db},   {31'd0, m_db});
    chk("press",   {31'd0, press_pulse},   {31'd0, m_press});
    chk("release", {31'd0, release_pulse}, {31'd0, m_rel});
    chk("long",    {31'd0, long_press},    {31'd0, m_long});
    if (press_pulse)   begin press_cnt++;     if (press_edge < 0) press_edge = edge_no; end
    if (release_pulse) begin rel_cnt++;       if (rel_edge < 0)   rel_edge = edge_no;   end
    if (long_press)    begin long_cnt_seen++; if (long_edge < 0)  long_edge = edge_no;  end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    clr_counts();
    mark(1'b1);
    ticks(3);                                // held in reset
    chk("rst_db",   {31'd0, button_n_db}, 32'd1);
    chk("rst_puls", {29'd0, press_pulse, release_pulse, long_press}, 32'd0);
    rst_n = 1'b1;
    ticks(5);

    // Clean press, then long press and no repeat
    clr_counts();
    mark(1'b0);
    ticks(100);
    chk("press_edge", press_edge, 32'd18);
    chk("long_edge",  long_edge,  32'd82);
    ticks(200);
    chk("long_once",  long_cnt_seen, 32'd1);
    chk("press_once", press_cnt, 32'd1);

    // Clean release
    clr_counts();
    mark(1'b1);
    ticks(25);
    chk("rel_edge", rel_edge, 32'd18);
    chk("rel_db",   {31'd0, button_n_db}, 32'd1);

    // Press bounce: 10 low, 3 high, then low held
    clr_counts();
    mark(1'b0); ticks(10);
    mark(1'b1); ticks(3);
    chk("bounce_none", press_cnt, 32'd0);
    mark(1'b0); ticks(25);
    chk("bounce_edge", press_edge, 32'd18);
    chk("bounce_once", press_cnt, 32'd1);

    // Release glitch after long press
    ticks(80);
    clr_counts();
    mark(1'b1); ticks(5);
    mark(1'b0); ticks(150);
    chk("glitch_rel",  rel_cnt, 32'd0);
    chk("glitch_long", long_cnt_seen, 32'd0);
    chk("glitch_db",   {31'd0, button_n_db}, 32'd0);

    // Asynchronous reset while pressed
    rst_n = 1'b0;
    #1;
    chk("arst_db",   {31'd0, button_n_db}, 32'd1);
    chk("arst_puls", {29'd0, press_pulse, release_pulse, long_press}, 32'd0);
    model_reset();
    ticks(3);
    rst_n = 1'b1;
    clr_counts();
    mark(1'b0);
    ticks(25);
    chk("arst_press", press_edge, 32'd18);

    // Random segments around the qualification threshold
    for (int seg = 0; seg < 120; seg++) begin
      button_raw_n = ~button_raw_n;
      ticks($urandom_range(1, 24));
      if (($urandom_range(0, 9)) == 0) ticks(LONG_EDGES + 10);
    end
    button_raw_n = 1'b1;
    ticks(30);
    chk("final_db", {31'd0, button_n_db}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
